dma_ctrl: RTL and testbench

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dma_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
// Job-level DMA sequencer: splits a word-count job into AHB bursts that never
// cross a 1 KB boundary, and steps the input/output buffer address per beat.
module dma_ctrl #(
  parameter int MAX_BURST = 16
) (
  input  logic        I_DCTL_HCLK,
  input  logic        I_DCTL_HRESET_N,
  input  logic        I_DCTL_START,
  input  logic        I_DCTL_WRITE,
  input  logic [31:0] I_DCTL_BASE_ADDR,
  input  logic [15:0] I_DCTL_WORDS,
  input  logic        I_DCTL_ABORT,
  input  logic        I_DCTL_DMA_READY,
  input  logic        I_DCTL_BEAT,
  output logic        O_DCTL_DMA_START,
  output logic [31:0] O_DCTL_DMA_ADDR,
  output logic [4:0]  O_DCTL_DMA_COUNT,
  output logic [2:0]  O_DCTL_DMA_SIZE,
  output logic        O_DCTL_DMA_WRITE,
  output logic        O_DCTL_DMA_STOP,
  output logic        O_DCTL_IMEM_WRITE,
  output logic [7:0]  O_DCTL_BUF_ADDR,
  output logic        O_DCTL_BUSY,
  output logic        O_DCTL_DONE
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] remain_q, remain_d;
  logic [4:0]  burst_q, burst_d;
  logic        dir_q, dir_d;
  logic        dma_start_q, dma_start_d;
  logic [31:0] dma_addr_q, dma_addr_d;
  logic [4:0]  dma_count_q, dma_count_d;
  logic        dma_write_q, dma_write_d;
  logic        dma_stop_q, dma_stop_d;
  logic [7:0]  buf_addr_q, buf_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [8:0]  room;
  logic [16:0] len;
  logic [4:0]  next_len;

  // Handshake: a burst request (DMA_START with ADDR/COUNT/WRITE) is held
  // stable until DMA_READY is seen high; START drops on the following cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    burst_d    = burst_q;
    dir_d      = dir_q;
    buf_addr_d = buf_addr_q;
    dma_stop_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_DCTL_START) begin
          if (I_DCTL_WORDS != 16'd0) begin
            addr_d     = {I_DCTL_BASE_ADDR[31:2], 2'b00};
            remain_d   = I_DCTL_WORDS;
            dir_d      = I_DCTL_WRITE;
            buf_addr_d = 8'd0;
            state_d    = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (I_DCTL_ABORT) begin
          dma_stop_d = 1'b1;
          state_d    = S_DONE;
        end else if (I_DCTL_DMA_READY) begin
          burst_d = dma_count_q;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // Abort takes priority over a coincident final beat.
        if (I_DCTL_ABORT) begin
          dma_stop_d = 1'b1;
          state_d    = S_DONE;
        end else if (I_DCTL_BEAT) begin
          remain_d   = remain_q - 16'd1;
          burst_d    = burst_q - 5'd1;
          buf_addr_d = buf_addr_q + 8'd1;
          if (burst_q == 5'd1) begin
            addr_d  = addr_q + {25'd0, dma_count_q, 2'b00};
            state_d = (remain_q == 16'd1) ? S_DONE : S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next burst length from the address/remaining count about to be latched.
  always_comb begin
    room = 9'd256 - {1'b0, addr_d[9:2]};
    len  = {1'b0, remain_d};
    if (len > 17'(MAX_BURST)) len = 17'(MAX_BURST);
    if (len > {8'd0, room})   len = {8'd0, room};
    next_len = len[4:0];
  end

  always_comb begin
    dma_start_d = dma_start_q;
    dma_addr_d  = dma_addr_q;
    dma_count_d = dma_count_q;
    dma_write_d = dma_write_q;
    if (state_d == S_REQ && state_q != S_REQ) begin
      dma_start_d = 1'b1;
      dma_addr_d  = addr_d;
      dma_count_d = next_len;
      dma_write_d = dir_d;
    end else if (state_q == S_REQ && state_d != S_REQ) begin
      dma_start_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge I_DCTL_HCLK or negedge I_DCTL_HRESET_N) begin
    if (!I_DCTL_HRESET_N) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      remain_q    <= 16'd0;
      burst_q     <= 5'd0;
      dir_q       <= 1'b0;
      dma_start_q <= 1'b0;
      dma_addr_q  <= 32'd0;
      dma_count_q <= 5'd0;
      dma_write_q <= 1'b0;
      dma_stop_q  <= 1'b0;
      buf_addr_q  <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      burst_q     <= burst_d;
      dir_q       <= dir_d;
      dma_start_q <= dma_start_d;
      dma_addr_q  <= dma_addr_d;
      dma_count_q <= dma_count_d;
      dma_write_q <= dma_write_d;
      dma_stop_q  <= dma_stop_d;
      buf_addr_q  <= buf_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign O_DCTL_DMA_START  = dma_start_q;
  assign O_DCTL_DMA_ADDR   = dma_addr_q;
  assign O_DCTL_DMA_COUNT  = dma_count_q;
  assign O_DCTL_DMA_SIZE   = 3'b010;
  assign O_DCTL_DMA_WRITE  = dma_write_q;
  assign O_DCTL_DMA_STOP   = dma_stop_q;
  assign O_DCTL_IMEM_WRITE = I_DCTL_BEAT & ~dir_q & (state_q == S_XFER);
  assign O_DCTL_BUF_ADDR   = buf_addr_q;
  assign O_DCTL_BUSY       = busy_q;
  assign O_DCTL_DONE       = done_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed-vector bench for dma_ctrl: expected bursts queued per job, a
// monitor pops and compares each new DMA_START and counts pulses.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, wr, abort, ready, beat;
  logic [31:0] base;
  logic [15:0] words;
  logic        dma_start, dma_write, dma_stop, imem_write, busy, done;
  logic [31:0] dma_addr;
  logic [4:0]  dma_count;
  logic [2:0]  dma_size;
  logic [7:0]  buf_addr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int imem_cnt = 0, done_cnt = 0, stop_cnt = 0;
  logic prev_start = 1'b0;
  logic [37:0] exp_q[$];

  always #5 clk = ~clk;

  dma_ctrl #(.MAX_BURST(16)) dut (
    .I_DCTL_HCLK(clk), .I_DCTL_HRESET_N(rst_n), .I_DCTL_START(start),
    .I_DCTL_WRITE(wr), .I_DCTL_BASE_ADDR(base), .I_DCTL_WORDS(words),
    .I_DCTL_ABORT(abort), .I_DCTL_DMA_READY(ready), .I_DCTL_BEAT(beat),
    .O_DCTL_DMA_START(dma_start), .O_DCTL_DMA_ADDR(dma_addr),
    .O_DCTL_DMA_COUNT(dma_count), .O_DCTL_DMA_SIZE(dma_size),
    .O_DCTL_DMA_WRITE(dma_write), .O_DCTL_DMA_STOP(dma_stop),
    .O_DCTL_IMEM_WRITE(imem_write), .O_DCTL_BUF_ADDR(buf_addr),
    .O_DCTL_BUSY(busy), .O_DCTL_DONE(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_burst(input logic w, input logic [31:0] a, input logic [4:0] c);
    exp_q.push_back({w, a, c});
  endtask

  // Monitor: samples 2 ns after the falling edge, clear of both edges.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_start = 1'b0;
    end else begin
      if (dma_start && !prev_start) begin
        if (exp_q.size() == 0) check("unexpected_dma_start", 64'd1, 64'd0);
        else begin
          check("burst_wr_addr_count", {26'd0, dma_write, dma_addr, dma_count}, {26'd0, exp_q.pop_front()});
          check("dma_size", {61'd0, dma_size}, 64'd2);
        end
      end
      if (imem_write) imem_cnt++;
      if (done) done_cnt++;
      if (dma_stop) stop_cnt++;
      prev_start = dma_start;
    end
  end

  task automatic run_job(input logic w, input logic [31:0] b, input logic [15:0] n,
                         input int abort_at, input bit poke,
                         input int exp_imem, input int exp_stop, input int exp_buf);
    int beat_no;
    int nb;
    bit fin;
    bit aborted;
    beat_no = 0;
    fin = 1'b0;
    imem_cnt = 0; done_cnt = 0; stop_cnt = 0;
    start = 1'b1; wr = w; base = b; words = n;
    tick();
    start = 1'b0; wr = 1'b0; base = 32'd0; words = 16'd0;
    cyc = 0;
    while (!fin && cyc < 3000) begin
      if (done) fin = 1'b1;
      else if (dma_start) begin
        nb = int'(dma_count);
        if (poke) begin
          beat = 1'b1; start = 1'b1; words = 16'd5; base = 32'hDEAD_0000; wr = ~w;
          tick();
          beat = 1'b0; start = 1'b0; words = 16'd0; base = 32'd0; wr = 1'b0;
        end
        repeat ($urandom_range(0, 2)) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < nb && !aborted; k++) begin
          repeat ($urandom_range(0, 1)) tick();
          beat = 1'b1;
          beat_no++;
          if (beat_no == abort_at) begin
            abort = 1'b1;
            aborted = 1'b1;
          end
          tick();
          beat = 1'b0;
          abort = 1'b0;
        end
      end else tick();
    end
    if (!fin) check("job_timeout", 64'd0, 64'd1);
    tick();
    check("busy_after_done", {63'd0, busy}, 64'd0);
    tick();
    tick();
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("imem_write_pulses", 64'(imem_cnt), 64'(exp_imem));
    check("stop_pulses", 64'(stop_cnt), 64'(exp_stop));
    check("bursts_outstanding", 64'(exp_q.size()), 64'd0);
    if (exp_buf >= 0) check("buf_addr_final", {56'd0, buf_addr}, 64'(exp_buf));
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; wr = 1'b0; abort = 1'b0; ready = 1'b0; beat = 1'b0;
    base = 32'd0; words = 16'd0;
    #3;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_dma_start", {63'd0, dma_start}, 64'd0);
    check("rst_dma_size", {61'd0, dma_size}, 64'd2);
    check("rst_buf_addr", {56'd0, buf_addr}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 40 words split 16/16/8, with a stray START and BEAT while busy
    push_burst(1'b0, 32'h1000, 5'd16);
    push_burst(1'b0, 32'h1040, 5'd16);
    push_burst(1'b0, 32'h1080, 5'd8);
    run_job(1'b0, 32'h1000, 16'd40, 0, 1'b1, 40, 0, 40);

    // 1 KB boundary split
    push_burst(1'b0, 32'h13F8, 5'd2);
    push_burst(1'b0, 32'h1400, 5'd8);
    run_job(1'b0, 32'h13F8, 16'd10, 0, 1'b0, 10, 0, 10);

    // empty job: no bursts, one DONE
    run_job(1'b0, 32'h5000, 16'd0, 0, 1'b0, 0, 0, -1);

    // write direction: no input-buffer writes
    push_burst(1'b1, 32'h2000, 5'd4);
    run_job(1'b1, 32'h2000, 16'd4, 0, 1'b0, 0, 0, 4);

    // abort on the 5th beat of a 16-beat burst
    push_burst(1'b0, 32'h4000, 5'd16);
    run_job(1'b0, 32'h4000, 16'd32, 5, 1'b0, 5, 1, -1);

    // unaligned base: low bits dropped, then boundary split
    push_burst(1'b1, 32'h0FC0, 5'd16);
    push_burst(1'b1, 32'h1000, 5'd4);
    run_job(1'b1, 32'h0000_0FC3, 16'd20, 0, 1'b0, 0, 0, 20);

    // address wrap past 2^32
    push_burst(1'b0, 32'hFFFF_FFF8, 5'd2);
    push_burst(1'b0, 32'h0000_0000, 5'd2);
    run_job(1'b0, 32'hFFFF_FFF8, 16'd4, 0, 1'b0, 4, 0, 4);

    // 260 words: buffer address wraps to 4
    for (int i = 0; i < 16; i++) push_burst(1'b0, 32'(i * 64), 5'd16);
    push_burst(1'b0, 32'h0400, 5'd4);
    run_job(1'b0, 32'h0000_0000, 16'd260, 0, 1'b0, 260, 0, 4);

    // asynchronous reset during XFER
    imem_cnt = 0; done_cnt = 0; stop_cnt = 0;
    push_burst(1'b0, 32'h3000, 5'd16);
    start = 1'b1; base = 32'h3000; words = 16'd20;
    tick();
    start = 1'b0; base = 32'd0; words = 16'd0;
    cyc = 0;
    while (!dma_start && cyc < 20) tick();
    check("reset_job_started", {63'd0, dma_start}, 64'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (3) begin
      beat = 1'b1;
      tick();
    end
    beat = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_buf_addr", {56'd0, buf_addr}, 64'd0);
    check("async_rst_dma_addr_count", {27'd0, dma_addr, dma_count}, 64'd0);
    check("async_rst_dma_size", {61'd0, dma_size}, 64'd2);
    check("async_rst_done_stop", {62'd0, done, dma_stop}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("reset_no_done", 64'(done_cnt), 64'd0);
    check("reset_no_stop", 64'(stop_cnt), 64'd0);
    check("reset_imem_before", 64'(imem_cnt), 64'd3);
    exp_q.delete();

    // normal job after reset release
    push_burst(1'b0, 32'h3004, 5'd3);
    run_job(1'b0, 32'h3004, 16'd3, 0, 1'b0, 3, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
